split_arbiter: RTL and testbench
================================

SPLIT_ARBITER -- requirements
Module: split_arbiter

Interface
REQ-001 Parameter SLAVE_LEN, default 2, width of slave-select fields.
REQ-002 Parameter NUM_SLAVES, default 3; slave codes 0..NUM_SLAVES-1 valid, others invalid.
REQ-003 Parameter MAX_HOLD, default 1024, max cycles one grant may be held.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 m1_request / m2_request  in  1 each  master bus request, level, held until released.
REQ-007 m1_slave_sel / m2_slave_sel  in  SLAVE_LEN each  target slave of each request.
REQ-008 tx_done  in  1  one-cycle pulse, current owner finished transaction.
REQ-009 split_en  in  NUM_SLAVES  per-slave split request; high = slave cannot complete now.
REQ-010 m1_grant / m2_grant  out  1 each  registered grant, level.
REQ-011 arb_busy  out  1  arbiter holds an active grant.
REQ-012 bus_busy  out  1  bus owned or split pending.
REQ-013 sel_master  out  1  mux steer, 0=M1, 1=M2; valid while arb_busy.
REQ-014 sel_slave  out  SLAVE_LEN  mux steer to target slave; valid while arb_busy.
REQ-015 split_pending  out  1  a split transaction is parked.
REQ-016 timeout  out  1  one-cycle pulse on forced release.

Function
REQ-017 FSM states IDLE, OWNED; plus split registers split_pending, split_master, split_slave; plus last_grant pointer and hold counter.
REQ-018 IDLE decision priority: (1) split_pending and split_en[split_slave]=0 -> resume split_master on split_slave, clear split_pending; (2) else round-robin among eligible requesters.
REQ-019 Eligible: request high, slave_sel valid, not split_master while pending, slave_sel != split_slave while pending.
REQ-020 Round-robin: both eligible -> grant the master not equal last_grant; single eligible -> grant it; last_grant updates on every grant.
REQ-021 Latency: decision in IDLE at cycle n -> grant, arb_busy, sel_master, sel_slave valid from cycle n+1; exactly one grant high at any time.
REQ-022 Resume grant ignores requester's current request/slave_sel; sel_slave = split_slave.
REQ-023 OWNED exit by tx_done: grant low next cycle, state IDLE; new grant no earlier than cycle after return to IDLE (one idle bus cycle minimum).
REQ-024 OWNED exit by split_en[sel_slave]=1: record split_master=sel_master, split_slave=sel_slave, split_pending=1, grant low next cycle, IDLE.
REQ-025 tx_done and split_en[sel_slave] same cycle: tx_done wins, no split recorded.
REQ-026 Owner drops request while OWNED (no tx_done): treated as abort, release as REQ-023.
REQ-027 Hold counter clears on grant, increments each OWNED cycle; reaching MAX_HOLD-1 with no other exit -> release, timeout pulse 1 cycle; if split_pending for same master, split_pending also cleared.
REQ-028 split_en on non-selected slaves ignored while OWNED.
REQ-029 Resumed split may itself split again; re-recorded per REQ-024.
REQ-030 Invalid slave_sel from a requester: never granted, no state change, other master unaffected.
REQ-031 bus_busy = arb_busy OR split_pending.

Reset
REQ-032 On reset: state IDLE, all grants 0, arb_busy 0, bus_busy 0, sel_master 0, sel_slave 0, split_pending 0, timeout 0, last_grant = M2 (so M1 wins first tie), hold counter 0.
REQ-033 Reset mid-OWNED or mid-split: all of REQ-032 applies next cycle; parked split discarded.

Verification
REQ-034 Both request at cycle 0 after reset, sel 1 and 2 -> m1_grant=1, sel_slave=1 at cycle 1; tx_done at cycle 4 -> grant low cycle 5; m2_grant=1, sel_slave=2 cycle 6.
REQ-035 M1 owns slave 0, split_en[0]=1 -> grant low, split_pending=1, bus_busy=1; M2 request slave 0 not granted; M2 request slave 2 granted.
REQ-036 Split parked, split_en[0] falls while both request -> M1 resumed on slave 0 regardless of round-robin, split_pending=0.
REQ-037 tx_done and split_en[sel_slave] same cycle -> clean release, split_pending stays 0.
REQ-038 MAX_HOLD=8, owner never signals done -> timeout pulse after 8th OWNED cycle, grant low next cycle; reset asserted during OWNED -> all outputs per REQ-032 next cycle.
REQ-039 Request with slave_sel=3 -> no grant ever, arb_busy stays 0.

Source files
------------

// File: rtl/split_arbiter.sv
// Two-master bus arbiter with split-transaction support.
// A granted master may be told by its slave to back off (split); the arbiter
// parks that master/slave pair and resumes it with top priority as soon as
// the slave withdraws its split request. Grants are round-robin, registered,
// and bounded in length by a hold counter that forces release on timeout.
//
// Handshake: a master raises mN_request (level) with mN_slave_sel and keeps it
// high until done; the arbiter answers with a registered mN_grant one cycle
// after its IDLE decision. The owner ends its tenure with a one-cycle tx_done
// pulse (or by dropping its request); the grant falls on the following cycle
// and at least one idle bus cycle passes before the next grant.
module split_arbiter #(
    parameter int SLAVE_LEN  = 2,
    parameter int NUM_SLAVES = 3,
    parameter int MAX_HOLD   = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 m1_request,
    input  logic                 m2_request,
    input  logic [SLAVE_LEN-1:0] m1_slave_sel,
    input  logic [SLAVE_LEN-1:0] m2_slave_sel,
    input  logic                 tx_done,
    input  logic [NUM_SLAVES-1:0] split_en,
    output logic                 m1_grant,
    output logic                 m2_grant,
    output logic                 arb_busy,
    output logic                 bus_busy,
    output logic                 sel_master,
    output logic [SLAVE_LEN-1:0] sel_slave,
    output logic                 split_pending,
    output logic                 timeout
);

    localparam int HOLD_W = $clog2(MAX_HOLD) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [SLAVE_LEN:0] SLAVE_LIMIT = (SLAVE_LEN + 1)'(NUM_SLAVES);

    // Master encoding used by sel_master, split_master and last_grant.
    localparam logic MASTER_M1 = 1'b0;
    localparam logic MASTER_M2 = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t               state;
    logic                 split_master;
    logic [SLAVE_LEN-1:0] split_slave;
    logic                 last_grant;
    logic [HOLD_W-1:0]    hold_cnt;

    logic m1_valid;
    logic m2_valid;
    logic m1_elig;
    logic m2_elig;
    logic pick_m2;
    logic owner_request;
    logic cur_split;
    logic parked_split;
    logic resume_ok;
    logic hold_expired;

    // Requester qualification: slave code in range and not colliding with a parked split.
    always_comb begin
        m1_valid = ({1'b0, m1_slave_sel} < SLAVE_LIMIT);
        m2_valid = ({1'b0, m2_slave_sel} < SLAVE_LIMIT);
        m1_elig  = m1_request && m1_valid &&
                   !(split_pending && ((split_master == MASTER_M1) || (m1_slave_sel == split_slave)));
        m2_elig  = m2_request && m2_valid &&
                   !(split_pending && ((split_master == MASTER_M2) || (m2_slave_sel == split_slave)));
        // Tie goes to the master that did not win last time.
        if (m1_elig && m2_elig) begin
            pick_m2 = (last_grant == MASTER_M1);
        end else begin
            pick_m2 = m2_elig;
        end
    end

    // Per-slave split lookups for the current owner's slave and the parked slave.
    always_comb begin
        cur_split    = 1'b0;
        parked_split = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_slave == SLAVE_LEN'(i)) begin
                cur_split = split_en[i];
            end
            if (split_slave == SLAVE_LEN'(i)) begin
                parked_split = split_en[i];
            end
        end
        owner_request = (sel_master == MASTER_M2) ? m2_request : m1_request;
        resume_ok     = split_pending && !parked_split;
        hold_expired  = (hold_cnt == HOLD_LAST);
    end

    // Arbitration FSM with registered grants, split bookkeeping and hold timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            m1_grant      <= 1'b0;
            m2_grant      <= 1'b0;
            arb_busy      <= 1'b0;
            sel_master    <= MASTER_M1;
            sel_slave     <= '0;
            split_pending <= 1'b0;
            split_master  <= MASTER_M1;
            split_slave   <= '0;
            timeout       <= 1'b0;
            last_grant    <= MASTER_M2;
            hold_cnt      <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (resume_ok) begin
                        // Parked split resumes ahead of any fresh request.
                        state         <= OWNED;
                        sel_master    <= split_master;
                        sel_slave     <= split_slave;
                        m1_grant      <= (split_master == MASTER_M1);
                        m2_grant      <= (split_master == MASTER_M2);
                        arb_busy      <= 1'b1;
                        split_pending <= 1'b0;
                        last_grant    <= split_master;
                        hold_cnt      <= '0;
                    end else if (m1_elig || m2_elig) begin
                        state      <= OWNED;
                        sel_master <= pick_m2 ? MASTER_M2 : MASTER_M1;
                        sel_slave  <= pick_m2 ? m2_slave_sel : m1_slave_sel;
                        m1_grant   <= !pick_m2;
                        m2_grant   <= pick_m2;
                        arb_busy   <= 1'b1;
                        last_grant <= pick_m2 ? MASTER_M2 : MASTER_M1;
                        hold_cnt   <= '0;
                    end
                end
                OWNED: begin
                    if (tx_done || cur_split || !owner_request || hold_expired) begin
                        state    <= IDLE;
                        m1_grant <= 1'b0;
                        m2_grant <= 1'b0;
                        arb_busy <= 1'b0;
                        if (tx_done) begin
                            // Completed transaction: a simultaneous split is moot.
                        end else if (cur_split) begin
                            split_pending <= 1'b1;
                            split_master  <= sel_master;
                            split_slave   <= sel_slave;
                        end else if (!owner_request) begin
                            // Owner aborted: plain release.
                        end else begin
                            timeout <= 1'b1;
                            if (split_pending && (split_master == sel_master)) begin
                                split_pending <= 1'b0;
                            end
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus_busy = arb_busy || split_pending;

endmodule

// File: tb/tb_split_arbiter.sv
// Directed bench for split_arbiter: round-robin, split park/resume,
// tx_done/split collision, abort, invalid slave, hold timeout and reset.
module tb_split_arbiter;

    localparam int SLAVE_LEN  = 2;
    localparam int NUM_SLAVES = 3;
    localparam int MAX_HOLD   = 8;

    logic                  clk;
    logic                  reset;
    logic                  m1_request;
    logic                  m2_request;
    logic [SLAVE_LEN-1:0]  m1_slave_sel;
    logic [SLAVE_LEN-1:0]  m2_slave_sel;
    logic                  tx_done;
    logic [NUM_SLAVES-1:0] split_en;
    logic                  m1_grant;
    logic                  m2_grant;
    logic                  arb_busy;
    logic                  bus_busy;
    logic                  sel_master;
    logic [SLAVE_LEN-1:0]  sel_slave;
    logic                  split_pending;
    logic                  timeout;

    int n_checks;
    int n_fail;

    split_arbiter #(
        .SLAVE_LEN (SLAVE_LEN),
        .NUM_SLAVES(NUM_SLAVES),
        .MAX_HOLD  (MAX_HOLD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .m1_request   (m1_request),
        .m2_request   (m2_request),
        .m1_slave_sel (m1_slave_sel),
        .m2_slave_sel (m2_slave_sel),
        .tx_done      (tx_done),
        .split_en     (split_en),
        .m1_grant     (m1_grant),
        .m2_grant     (m2_grant),
        .arb_busy     (arb_busy),
        .bus_busy     (bus_busy),
        .sel_master   (sel_master),
        .sel_slave    (sel_slave),
        .split_pending(split_pending),
        .timeout      (timeout)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and settle past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_m1_grant"}, 32'(m1_grant), 32'd0);
        check_eq({tag, "_m2_grant"}, 32'(m2_grant), 32'd0);
        check_eq({tag, "_arb_busy"}, 32'(arb_busy), 32'd0);
        check_eq({tag, "_bus_busy"}, 32'(bus_busy), 32'd0);
        check_eq({tag, "_sel_master"}, 32'(sel_master), 32'd0);
        check_eq({tag, "_sel_slave"}, 32'(sel_slave), 32'd0);
        check_eq({tag, "_split_pending"}, 32'(split_pending), 32'd0);
        check_eq({tag, "_timeout"}, 32'(timeout), 32'd0);
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        reset        = 1'b1;
        m1_request   = 1'b0;
        m2_request   = 1'b0;
        m1_slave_sel = '0;
        m2_slave_sel = '0;
        tx_done      = 1'b0;
        split_en     = '0;
        tick();
        tick();
        check_idle_outputs("reset");
        reset = 1'b0;

        // Both request at cycle 0: M1 wins the first tie.
        m1_request = 1'b1; m1_slave_sel = 2'd1;
        m2_request = 1'b1; m2_slave_sel = 2'd2;
        tick(); // cycle 1
        check_eq("rr_c1_m1_grant", 32'(m1_grant), 32'd1);
        check_eq("rr_c1_m2_grant", 32'(m2_grant), 32'd0);
        check_eq("rr_c1_sel_slave", 32'(sel_slave), 32'd1);
        check_eq("rr_c1_sel_master", 32'(sel_master), 32'd0);
        check_eq("rr_c1_arb_busy", 32'(arb_busy), 32'd1);
        tick(); tick(); // cycle 3
        check_eq("rr_c3_m1_grant", 32'(m1_grant), 32'd1);
        tick(); // cycle 4
        tx_done = 1'b1; m1_request = 1'b0;
        tick(); // cycle 5
        tx_done = 1'b0;
        check_eq("rr_c5_m1_grant", 32'(m1_grant), 32'd0);
        check_eq("rr_c5_m2_grant", 32'(m2_grant), 32'd0);
        check_eq("rr_c5_arb_busy", 32'(arb_busy), 32'd0);
        tick(); // cycle 6
        check_eq("rr_c6_m2_grant", 32'(m2_grant), 32'd1);
        check_eq("rr_c6_sel_slave", 32'(sel_slave), 32'd2);
        check_eq("rr_c6_sel_master", 32'(sel_master), 32'd1);
        tx_done = 1'b1; m2_request = 1'b0;
        tick();
        tx_done = 1'b0;
        check_eq("rr_rel_m2_grant", 32'(m2_grant), 32'd0);

        // M1 on slave 0 gets split and parked.
        m1_request = 1'b1; m1_slave_sel = 2'd0;
        tick();
        check_eq("sp_m1_grant", 32'(m1_grant), 32'd1);
        check_eq("sp_sel_slave", 32'(sel_slave), 32'd0);
        split_en = 3'b001;
        tick();
        check_eq("sp_park_m1_grant", 32'(m1_grant), 32'd0);
        check_eq("sp_park_pending", 32'(split_pending), 32'd1);
        check_eq("sp_park_bus_busy", 32'(bus_busy), 32'd1);
        check_eq("sp_park_arb_busy", 32'(arb_busy), 32'd0);
        // M2 aimed at the split slave stays blocked.
        m2_request = 1'b1; m2_slave_sel = 2'd0;
        tick();
        check_eq("sp_blk1_m2_grant", 32'(m2_grant), 32'd0);
        tick();
        check_eq("sp_blk2_m2_grant", 32'(m2_grant), 32'd0);
        check_eq("sp_blk2_arb_busy", 32'(arb_busy), 32'd0);

        // Split clears while M2 is eligible and round-robin favours M2: M1 resumes.
        m1_slave_sel = 2'd1; m2_slave_sel = 2'd2; split_en = 3'b000;
        tick();
        check_eq("res_m1_grant", 32'(m1_grant), 32'd1);
        check_eq("res_m2_grant", 32'(m2_grant), 32'd0);
        check_eq("res_sel_slave", 32'(sel_slave), 32'd0);
        check_eq("res_pending", 32'(split_pending), 32'd0);

        // Resumed transaction splits again; M2 on slave 2 then gets the bus.
        split_en = 3'b001;
        tick();
        check_eq("resplit_m1_grant", 32'(m1_grant), 32'd0);
        check_eq("resplit_pending", 32'(split_pending), 32'd1);
        tick();
        check_eq("sp2_m2_grant", 32'(m2_grant), 32'd1);
        check_eq("sp2_sel_slave", 32'(sel_slave), 32'd2);
        check_eq("sp2_bus_busy", 32'(bus_busy), 32'd1);
        // Split on a slave other than the owner's is ignored.
        split_en = 3'b011;
        tick();
        check_eq("other_split_m2_grant", 32'(m2_grant), 32'd1);
        check_eq("other_split_pending", 32'(split_pending), 32'd1);
        split_en = 3'b000; tx_done = 1'b1; m2_request = 1'b0;
        tick();
        tx_done = 1'b0;
        check_eq("sp2_rel_m2_grant", 32'(m2_grant), 32'd0);
        check_eq("sp2_rel_m1_grant", 32'(m1_grant), 32'd0);
        tick();
        check_eq("res2_m1_grant", 32'(m1_grant), 32'd1);
        check_eq("res2_sel_slave", 32'(sel_slave), 32'd0);
        check_eq("res2_pending", 32'(split_pending), 32'd0);
        tx_done = 1'b1; m1_request = 1'b0;
        tick();
        tx_done = 1'b0;
        check_eq("res2_rel_m1_grant", 32'(m1_grant), 32'd0);
        check_eq("res2_rel_bus_busy", 32'(bus_busy), 32'd0);

        // tx_done and split on the owner's slave in the same cycle.
        m2_request = 1'b1; m2_slave_sel = 2'd1;
        tick();
        check_eq("coll_m2_grant", 32'(m2_grant), 32'd1);
        check_eq("coll_sel_slave", 32'(sel_slave), 32'd1);
        tx_done = 1'b1; split_en = 3'b010; m2_request = 1'b0;
        tick();
        tx_done = 1'b0; split_en = 3'b000;
        check_eq("coll_rel_m2_grant", 32'(m2_grant), 32'd0);
        check_eq("coll_rel_pending", 32'(split_pending), 32'd0);
        check_eq("coll_rel_bus_busy", 32'(bus_busy), 32'd0);

        // Owner drops its request: abort release.
        m1_request = 1'b1; m1_slave_sel = 2'd2;
        tick();
        check_eq("abort_m1_grant", 32'(m1_grant), 32'd1);
        m1_request = 1'b0;
        tick();
        check_eq("abort_rel_m1_grant", 32'(m1_grant), 32'd0);
        check_eq("abort_rel_arb_busy", 32'(arb_busy), 32'd0);
        check_eq("abort_rel_timeout", 32'(timeout), 32'd0);

        // Invalid slave code is never granted; the other master still is.
        m1_request = 1'b1; m1_slave_sel = 2'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("inv_arb_busy", 32'(arb_busy), 32'd0);
            check_eq("inv_m1_grant", 32'(m1_grant), 32'd0);
        end
        m2_request = 1'b1; m2_slave_sel = 2'd1;
        tick();
        check_eq("inv_other_m2_grant", 32'(m2_grant), 32'd1);
        check_eq("inv_other_m1_grant", 32'(m1_grant), 32'd0);
        check_eq("inv_other_sel_slave", 32'(sel_slave), 32'd1);
        m2_request = 1'b0; m1_request = 1'b0;
        tick();
        check_eq("inv_rel_m2_grant", 32'(m2_grant), 32'd0);

        // Hold timeout: grant for MAX_HOLD cycles, then forced release with pulse.
        m1_request = 1'b1; m1_slave_sel = 2'd1;
        for (int k = 1; k <= MAX_HOLD; k++) begin
            tick();
            check_eq("hold_m1_grant", 32'(m1_grant), 32'd1);
            check_eq("hold_timeout", 32'(timeout), 32'd0);
        end
        tick();
        check_eq("to_m1_grant", 32'(m1_grant), 32'd0);
        check_eq("to_pulse", 32'(timeout), 32'd1);
        tick();
        check_eq("to_after_pulse", 32'(timeout), 32'd0);
        check_eq("to_regrant_m1", 32'(m1_grant), 32'd1);

        // Reset while owned.
        reset = 1'b1;
        tick();
        check_idle_outputs("rst_owned");
        reset = 1'b0; m1_request = 1'b0;
        tick();

        // Reset while a split is parked discards it.
        m1_request = 1'b1; m1_slave_sel = 2'd0;
        tick();
        check_eq("rs_m1_grant", 32'(m1_grant), 32'd1);
        split_en = 3'b001;
        tick();
        check_eq("rs_pending", 32'(split_pending), 32'd1);
        reset = 1'b1;
        tick();
        check_idle_outputs("rst_split");
        reset = 1'b0; split_en = 3'b000; m1_request = 1'b0;
        tick();
        check_eq("rs_no_resume", 32'(m1_grant), 32'd0);
        check_eq("rs_no_pending", 32'(split_pending), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
